// File: rtl/sbox_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aes_sbox / sbox_scheduler: AES S-box and a round-robin SubBytes/SubWord   |
// | scheduler sharing SBOX_LANES S-boxes. Revision 1.0                       |
// +--------------------------------------------------------------------------+

module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  localparam logic [0:255][7:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign dout = SBOX_TABLE[din];

endmodule

module sbox_scheduler #(
  parameter int SBOX_LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         st_req_valid,
  output logic         st_req_ready,
  input  logic [127:0] st_req_data,
  output logic         st_rsp_valid,
  output logic [127:0] st_rsp_data,
  input  logic         ks_req_valid,
  output logic         ks_req_ready,
  input  logic [31:0]  ks_req_word,
  output logic         ks_rsp_valid,
  output logic [31:0]  ks_rsp_word,
  output logic         busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic OWN_KS = 1'b0;
  localparam logic OWN_ST = 1'b1;

  localparam logic [3:0] ST_LAST = 4'(16 / SBOX_LANES - 1);
  localparam logic [3:0] KS_LAST = 4'(4 / SBOX_LANES - 1);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [3:0]        cnt;
  logic              token;
  logic              owner;
  logic [0:15][7:0]  operand;
  logic [0:15][7:0]  st_res;
  logic [0:3][7:0]   ks_res;

  logic              grant_st;
  logic              grant_ks;
  logic              accept;
  logic              last_chunk;

  logic [SBOX_LANES-1:0][3:0] byte_idx;
  logic [SBOX_LANES-1:0][7:0] lane_in;
  logic [SBOX_LANES-1:0][7:0] lane_out;

  // Ready is a grant: only in IDLE, never while reset is asserted, and the
  // token only matters when both requesters are competing.
  always_comb begin
    grant_st = 1'b0;
    grant_ks = 1'b0;
    if (rst_n && (state == S_IDLE)) begin
      if (st_req_valid && (!ks_req_valid || (token == OWN_ST))) begin
        grant_st = 1'b1;
      end else if (ks_req_valid) begin
        grant_ks = 1'b1;
      end
    end
  end

  assign accept     = grant_st | grant_ks;
  assign last_chunk = (cnt == ((owner == OWN_ST) ? ST_LAST : KS_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_RUN;
      S_RUN:   if (last_chunk) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    st_req_ready = grant_st;
    ks_req_ready = grant_ks;
    busy         = (state != S_IDLE);
    st_rsp_valid = (state == S_DONE) && (owner == OWN_ST);
    ks_rsp_valid = (state == S_DONE) && (owner == OWN_KS);
  end

  // A key word is parked in operand bytes 0..3 so both owners share one
  // byte numbering for lane selection.
  generate
    for (genvar j = 0; j < SBOX_LANES; j++) begin : g_lane
      assign byte_idx[j] = 4'(cnt * 4'(SBOX_LANES) + 4'(j));
      assign lane_in[j]  = operand[byte_idx[j]];
      aes_sbox u_sbox (
        .din  (lane_in[j]),
        .dout (lane_out[j])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 4'd0;
      token   <= OWN_KS;
      owner   <= OWN_KS;
      operand <= '0;
      st_res  <= '0;
      ks_res  <= '0;
    end else if (accept) begin
      owner   <= grant_st;
      operand <= grant_st ? st_req_data : {ks_req_word, 96'd0};
      cnt     <= 4'd0;
      if (st_req_valid && ks_req_valid) begin
        token <= grant_ks ? OWN_ST : OWN_KS;
      end
    end else if (state == S_RUN) begin
      for (int j = 0; j < SBOX_LANES; j++) begin
        if (owner == OWN_ST) begin
          st_res[byte_idx[j]] <= lane_out[j];
        end else begin
          ks_res[byte_idx[j][1:0]] <= lane_out[j];
        end
      end
      // Holding on the final chunk keeps cnt from wrapping when SBOX_LANES=1.
      if (!last_chunk) begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  assign st_rsp_data = st_res;
  assign ks_rsp_word = ks_res;

endmodule

`default_nettype wire

// File: tb/tb_sbox_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sbox_scheduler: directed self-checking bench, lanes 4 plus 2 and 1.   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+

module tb_sbox_scheduler;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         st_req_valid = 1'b0;
  logic [127:0] st_req_data = '0;
  logic         ks_req_valid = 1'b0;
  logic [31:0]  ks_req_word = '0;

  logic         st_req_ready, st_rsp_valid, ks_req_ready, ks_rsp_valid, busy;
  logic [127:0] st_rsp_data;
  logic [31:0]  ks_rsp_word;

  logic         st_req_ready2, st_rsp_valid2, ks_req_ready2, ks_rsp_valid2, busy2;
  logic [127:0] st_rsp_data2;
  logic [31:0]  ks_rsp_word2;

  logic         st_req_ready1, st_rsp_valid1, ks_req_ready1, ks_rsp_valid1, busy1;
  logic [127:0] st_rsp_data1;
  logic [31:0]  ks_rsp_word1;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] VEC_IN   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] VEC_OUT  = 128'h638293C3_1BFC33F5_C4EEACEA_4BC12816;
  localparam logic [127:0] ZERO_OUT = {16{8'h63}};
  localparam logic [127:0] BND_IN   = 128'h00010200_53050653_FF090AFF_0C0D0E0F;
  localparam logic [127:0] BND_OUT  = 128'h637C7763_ED6B6FED_16016716_FED7AB76;

  always #5 clk = ~clk;

  sbox_scheduler #(.SBOX_LANES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_req_valid(st_req_valid), .st_req_ready(st_req_ready), .st_req_data(st_req_data),
    .st_rsp_valid(st_rsp_valid), .st_rsp_data(st_rsp_data),
    .ks_req_valid(ks_req_valid), .ks_req_ready(ks_req_ready), .ks_req_word(ks_req_word),
    .ks_rsp_valid(ks_rsp_valid), .ks_rsp_word(ks_rsp_word), .busy(busy)
  );

  sbox_scheduler #(.SBOX_LANES(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .st_req_valid(st_req_valid), .st_req_ready(st_req_ready2), .st_req_data(st_req_data),
    .st_rsp_valid(st_rsp_valid2), .st_rsp_data(st_rsp_data2),
    .ks_req_valid(ks_req_valid), .ks_req_ready(ks_req_ready2), .ks_req_word(ks_req_word),
    .ks_rsp_valid(ks_rsp_valid2), .ks_rsp_word(ks_rsp_word2), .busy(busy2)
  );

  sbox_scheduler #(.SBOX_LANES(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .st_req_valid(st_req_valid), .st_req_ready(st_req_ready1), .st_req_data(st_req_data),
    .st_rsp_valid(st_rsp_valid1), .st_rsp_data(st_rsp_data1),
    .ks_req_valid(ks_req_valid), .ks_req_ready(ks_req_ready1), .ks_req_word(ks_req_word),
    .ks_rsp_valid(ks_rsp_valid1), .ks_rsp_word(ks_rsp_word1), .busy(busy1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Called in cycle c1; returns the cycle index of the response, or -1 on timeout.
  task automatic wait_rsp(input bit is_key, output int cyc);
    cyc = 1;
    while (((is_key ? ks_rsp_valid : st_rsp_valid) !== 1'b1) && (cyc < 40)) begin
      tick();
      cyc++;
    end
    if (cyc >= 40) cyc = -1;
  endtask

  task automatic test_reset();
    tick();
    st_req_valid = 1'b1;
    ks_req_valid = 1'b1;
    rst_n = 1'b0;
    #2;
    checks++;
    if ({st_req_ready, ks_req_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b expected 00", {st_req_ready, ks_req_ready});
    end
    checks++;
    if ({busy, st_rsp_valid, ks_rsp_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b expected 000", {busy, st_rsp_valid, ks_rsp_valid});
    end
    checks++;
    if (st_rsp_data !== 128'd0) begin
      errors++; $display("FAIL reset_st_data: got %h expected 0", st_rsp_data);
    end
    checks++;
    if (ks_rsp_word !== 32'd0) begin
      errors++; $display("FAIL reset_ks_word: got %h expected 0", ks_rsp_word);
    end
    st_req_valid = 1'b0;
    ks_req_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_state_zero();
    int cyc;
    st_req_data  = 128'd0;
    st_req_valid = 1'b1;
    #1;
    checks++;
    if (st_req_ready !== 1'b1) begin
      errors++; $display("FAIL zero_ready: got %b expected 1", st_req_ready);
    end
    tick();
    st_req_valid = 1'b0;
    st_req_data  = {$urandom, $urandom, $urandom, $urandom};
    wait_rsp(1'b0, cyc);
    checks++;
    if (cyc !== 5) begin
      errors++; $display("FAIL zero_latency: got %0d expected 5", cyc);
    end
    checks++;
    if (st_rsp_data !== ZERO_OUT) begin
      errors++; $display("FAIL zero_data: got %h expected %h", st_rsp_data, ZERO_OUT);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL zero_busy_done: got %b expected 1", busy);
    end
    tick();
    checks++;
    if ({st_rsp_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL zero_pulse_end: got %b expected 00", {st_rsp_valid, busy});
    end
    checks++;
    if (st_rsp_data !== ZERO_OUT) begin
      errors++; $display("FAIL zero_hold: got %h expected %h", st_rsp_data, ZERO_OUT);
    end
  endtask

  task automatic test_key();
    int cyc;
    ks_req_word  = 32'hCF4F3C09;
    ks_req_valid = 1'b1;
    #1;
    checks++;
    if (ks_req_ready !== 1'b1) begin
      errors++; $display("FAIL key_ready: got %b expected 1", ks_req_ready);
    end
    tick();
    ks_req_valid = 1'b0;
    ks_req_word  = 32'hDEADBEEF;
    wait_rsp(1'b1, cyc);
    checks++;
    if (cyc !== 2) begin
      errors++; $display("FAIL key_latency: got %0d expected 2", cyc);
    end
    checks++;
    if (ks_rsp_word !== 32'h8A84EB01) begin
      errors++; $display("FAIL key_word: got %h expected 8a84eb01", ks_rsp_word);
    end
    checks++;
    if ((st_rsp_data !== ZERO_OUT) || (st_rsp_valid !== 1'b0)) begin
      errors++; $display("FAIL key_st_untouched: got %h/%b expected %h/0", st_rsp_data, st_rsp_valid, ZERO_OUT);
    end
  endtask

  // Starts in the DONE cycle of the previous key job.
  task automatic test_back_to_back();
    int cyc;
    ks_req_word  = 32'h005311FF;
    ks_req_valid = 1'b1;
    #1;
    checks++;
    if (ks_req_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_ready_in_done: got %b expected 0", ks_req_ready);
    end
    tick();
    checks++;
    if (ks_req_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_ready_next: got %b expected 1", ks_req_ready);
    end
    tick();
    ks_req_valid = 1'b0;
    wait_rsp(1'b1, cyc);
    checks++;
    if ((cyc !== 2) || (ks_rsp_word !== 32'h63ED8216)) begin
      errors++; $display("FAIL b2b_key_boundary: got %0d/%h expected 2/63ed8216", cyc, ks_rsp_word);
    end
    tick();
  endtask

  task automatic test_lanes();
    int c4, c2, c1;
    logic [127:0] d4, d2, d1;
    c4 = 0; c2 = 0; c1 = 0;
    d4 = '0; d2 = '0; d1 = '0;
    apply_reset();
    st_req_data  = VEC_IN;
    st_req_valid = 1'b1;
    #1;
    checks++;
    if ({st_req_ready, st_req_ready2, st_req_ready1} !== 3'b111) begin
      errors++; $display("FAIL lanes_ready: got %b expected 111", {st_req_ready, st_req_ready2, st_req_ready1});
    end
    tick();
    st_req_valid = 1'b0;
    st_req_data  = {$urandom, $urandom, $urandom, $urandom};
    for (int cyc = 1; cyc < 25; cyc++) begin
      if ((st_rsp_valid === 1'b1) && (c4 == 0)) begin c4 = cyc; d4 = st_rsp_data; end
      if ((st_rsp_valid2 === 1'b1) && (c2 == 0)) begin c2 = cyc; d2 = st_rsp_data2; end
      if ((st_rsp_valid1 === 1'b1) && (c1 == 0)) begin c1 = cyc; d1 = st_rsp_data1; end
      tick();
    end
    checks++;
    if ((c4 !== 5) || (d4 !== VEC_OUT)) begin
      errors++; $display("FAIL lanes4: got c%0d %h expected c5 %h", c4, d4, VEC_OUT);
    end
    checks++;
    if ((c2 !== 9) || (d2 !== VEC_OUT)) begin
      errors++; $display("FAIL lanes2: got c%0d %h expected c9 %h", c2, d2, VEC_OUT);
    end
    checks++;
    if ((c1 !== 17) || (d1 !== VEC_OUT)) begin
      errors++; $display("FAIL lanes1: got c%0d %h expected c17 %h", c1, d1, VEC_OUT);
    end
  endtask

  task automatic test_boundary();
    int cyc;
    st_req_data  = BND_IN;
    st_req_valid = 1'b1;
    #1;
    checks++;
    if (st_req_ready !== 1'b1) begin
      errors++; $display("FAIL bnd_ready: got %b expected 1", st_req_ready);
    end
    tick();
    st_req_valid = 1'b0;
    wait_rsp(1'b0, cyc);
    checks++;
    if ((cyc !== 5) || (st_rsp_data !== BND_OUT)) begin
      errors++; $display("FAIL bnd_data: got c%0d %h expected c5 %h", cyc, st_rsp_data, BND_OUT);
    end
    tick();
  endtask

  task automatic test_arbitration();
    int ng, both_hi;
    logic [2:0] who;
    int gc [3];
    ng = 0; both_hi = 0; who = 3'b000;
    gc[0] = -1; gc[1] = -1; gc[2] = -1;
    apply_reset();
    st_req_data  = VEC_IN;
    ks_req_word  = 32'hCF4F3C09;
    st_req_valid = 1'b1;
    ks_req_valid = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      #1;
      if ((st_req_ready === 1'b1) && (ks_req_ready === 1'b1)) both_hi++;
      if (((st_req_ready === 1'b1) || (ks_req_ready === 1'b1)) && (ng < 3)) begin
        who[2-ng] = st_req_ready;
        gc[ng] = cyc;
        ng++;
      end
      tick();
    end
    st_req_valid = 1'b0;
    ks_req_valid = 1'b0;
    checks++;
    if (both_hi !== 0) begin
      errors++; $display("FAIL arb_both_ready: got %0d cycles expected 0", both_hi);
    end
    checks++;
    if ((ng !== 3) || (who !== 3'b010)) begin
      errors++; $display("FAIL arb_order: got %0d grants %b expected 3 grants 010", ng, who);
    end
    checks++;
    if ((gc[0] !== 0) || (gc[1] !== 3) || (gc[2] !== 9)) begin
      errors++; $display("FAIL arb_cycles: got %0d,%0d,%0d expected 0,3,9", gc[0], gc[1], gc[2]);
    end
    checks++;
    if ((st_rsp_data !== VEC_OUT) || (ks_rsp_word !== 32'h8A84EB01)) begin
      errors++; $display("FAIL arb_results: got %h/%h expected %h/8a84eb01", st_rsp_data, ks_rsp_word, VEC_OUT);
    end
    tick();
  endtask

  task automatic test_drop();
    apply_reset();
    ks_req_word  = 32'h01020304;
    ks_req_valid = 1'b1;
    #1;
    checks++;
    if (ks_req_ready !== 1'b1) begin
      errors++; $display("FAIL drop_key_ready: got %b expected 1", ks_req_ready);
    end
    tick();
    ks_req_valid = 1'b0;
    st_req_valid = 1'b1;
    #1;
    checks++;
    if (st_req_ready !== 1'b0) begin
      errors++; $display("FAIL drop_ready_in_run: got %b expected 0", st_req_ready);
    end
    tick();
    st_req_valid = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL drop_no_job: got busy %b expected 0", busy);
    end
    st_req_valid = 1'b1;
    ks_req_valid = 1'b1;
    #1;
    checks++;
    if ({st_req_ready, ks_req_ready} !== 2'b01) begin
      errors++; $display("FAIL drop_token: got %b expected 01", {st_req_ready, ks_req_ready});
    end
    tick();
    st_req_valid = 1'b0;
    ks_req_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_midrun();
    int cyc;
    st_req_data  = VEC_IN;
    st_req_valid = 1'b1;
    #1;
    checks++;
    if (st_req_ready !== 1'b1) begin
      errors++; $display("FAIL mid_ready: got %b expected 1", st_req_ready);
    end
    tick();
    st_req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, st_rsp_valid} !== 2'b00 || st_rsp_data !== 128'd0) begin
      errors++; $display("FAIL mid_reset_state: got %b %h expected 00 0", {busy, st_rsp_valid}, st_rsp_data);
    end
    #1;
    rst_n = 1'b1;
    st_req_data  = 128'd0;
    st_req_valid = 1'b1;
    #1;
    checks++;
    if (st_req_ready !== 1'b1) begin
      errors++; $display("FAIL mid_accept_after: got %b expected 1", st_req_ready);
    end
    tick();
    st_req_valid = 1'b0;
    wait_rsp(1'b0, cyc);
    checks++;
    if ((cyc !== 5) || (st_rsp_data !== ZERO_OUT)) begin
      errors++; $display("FAIL mid_new_job: got c%0d %h expected c5 %h", cyc, st_rsp_data, ZERO_OUT);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_state_zero();
    test_key();
    test_back_to_back();
    test_lanes();
    test_boundary();
    test_arbitration();
    test_drop();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
